// File: rtl/tilemap_pkg.sv
// Shared tilemap definitions: map geometry, bus widths and writer state encoding.
package tilemap_pkg;

    localparam int TILEMAP_LENGTH = 2000;   // tiles per row
    localparam int TILEMAP_ROWS   = 16;     // rows in the map

    localparam int ADDR_W = 15;             // flat tile address width
    localparam int TILE_W = 4;              // tile code width
    localparam int X_W    = 11;             // column coordinate width
    localparam int Y_W    = 4;              // row coordinate width

    localparam logic [TILE_W-1:0] EMPTY_TILE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        ERR   = 2'd3
    } writer_state_t;

endpackage

// File: rtl/tilemap_writer_if.sv
// Command handshake and tilemap write bus of the tilemap writer.
// Handshake: a command is taken on the rising edge where enable=1 and done=1;
// enable is ignored while done=0. Each cycle with memory_wren=1 writes
// memory_data to memory_address; both buses read 0 whenever memory_wren=0.
interface tilemap_writer_if;
    import tilemap_pkg::*;

    logic              enable;
    logic              mode;
    logic [X_W-1:0]    x_location;
    logic [Y_W-1:0]    y_location;
    logic [Y_W-1:0]    y_end;
    logic [TILE_W-1:0] tile_value;

    logic [ADDR_W-1:0] memory_address;
    logic [TILE_W-1:0] memory_data;
    logic              memory_wren;
    logic              done;
    logic              error;

    // Command source; receives the write bus and status.
    modport master (
        output enable, mode, x_location, y_location, y_end, tile_value,
        input  memory_address, memory_data, memory_wren, done, error
    );

    // The writer itself.
    modport slave (
        input  enable, mode, x_location, y_location, y_end, tile_value,
        output memory_address, memory_data, memory_wren, done, error
    );

endinterface

// File: rtl/tilemap_address.sv
// Combinational tile address: x + y * row_length. Also used by the collision
// detector, so it stays free of any writer state.
module tilemap_address
    import tilemap_pkg::*;
#(
    parameter int ROW_LENGTH = TILEMAP_LENGTH
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] address
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_LENGTH);

    // Flat row-major address; legal coordinates never exceed 31999.
    always_comb begin
        address = ADDR_W'(x) + (ADDR_W'(y) * ROW_STEP);
    end

endmodule

// File: rtl/tilemap_writer.sv
// Tilemap writer: writes one tile, or fills a column over a row range, one
// tile per cycle. Invalid commands are rejected through a one-cycle ERR state
// that leaves a sticky error flag.
module tilemap_writer #(
    parameter int TILEMAP_LENGTH = tilemap_pkg::TILEMAP_LENGTH,
    parameter int TILEMAP_ROWS   = tilemap_pkg::TILEMAP_ROWS
) (
    input  logic                       clock,
    input  logic                       resetn,
    tilemap_writer_if.slave            bus,
    output tilemap_pkg::writer_state_t state
);
    import tilemap_pkg::*;

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(TILEMAP_LENGTH);

    writer_state_t     state_q;
    logic              mode_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [Y_W-1:0]    y_end_q;
    logic [Y_W-1:0]    row_q;
    logic [TILE_W-1:0] tile_q;

    logic [ADDR_W-1:0] addr_q;
    logic [TILE_W-1:0] data_q;
    logic              wren_q;
    logic              done_q;
    logic              error_q;

    logic [ADDR_W-1:0] setup_addr;
    logic              cmd_invalid;

    // Start address of the latched command, computed during SETUP.
    tilemap_address #(
        .ROW_LENGTH (TILEMAP_LENGTH)
    ) u_address (
        .x       (x_q),
        .y       (y_q),
        .address (setup_addr)
    );

    // Reject off-map columns/rows and fills whose row range runs backwards.
    always_comb begin
        cmd_invalid = (int'(bus.x_location) >= TILEMAP_LENGTH)
                   || (int'(bus.y_location) >= TILEMAP_ROWS)
                   || (bus.mode && (bus.y_end < bus.y_location))
                   || (bus.mode && (int'(bus.y_end) >= TILEMAP_ROWS));
    end

    // Command FSM with registered bus outputs; address steps by one row per write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            y_end_q <= '0;
            row_q   <= '0;
            tile_q  <= EMPTY_TILE;
            addr_q  <= '0;
            data_q  <= EMPTY_TILE;
            wren_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        mode_q  <= bus.mode;
                        x_q     <= bus.x_location;
                        y_q     <= bus.y_location;
                        y_end_q <= bus.y_end;
                        row_q   <= bus.y_location;
                        tile_q  <= bus.tile_value;
                        error_q <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= cmd_invalid ? ERR : SETUP;
                    end
                end
                SETUP: begin
                    addr_q  <= setup_addr;
                    data_q  <= tile_q;
                    wren_q  <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (!mode_q || (row_q == y_end_q)) begin
                        addr_q  <= '0;
                        data_q  <= EMPTY_TILE;
                        wren_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        row_q  <= row_q + 1'b1;
                        addr_q <= addr_q + ROW_STEP;
                    end
                end
                ERR: begin
                    error_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    addr_q  <= '0;
                    data_q  <= EMPTY_TILE;
                    wren_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.memory_address = addr_q;
    assign bus.memory_data    = data_q;
    assign bus.memory_wren    = wren_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign state              = state_q;

endmodule

// File: doc/tilemap_writer.md
TILEMAP_WRITER -- requirements
Module: tilemap_writer

Interface
REQ-001 Parameter TILEMAP_LENGTH, default 2000, is the tilemap row length in tiles.
REQ-002 Parameter TILEMAP_ROWS, default 16, is the number of tilemap rows.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  command start; sampled only in IDLE.
REQ-006 mode  input  1  0 = single-tile write, 1 = column fill.
REQ-007 x_location  input  11  target column, in tiles.
REQ-008 y_location  input  4  target row; start row in fill mode.
REQ-009 y_end  input  4  last row in fill mode; ignored in single mode.
REQ-010 tile_value  input  4  tile code to write; 0 = empty tile.
REQ-011 memory_address  output  15  tilemap write address.
REQ-012 memory_data  output  4  tilemap write data.
REQ-013 memory_wren  output  1  write strobe; one tile is written per cycle while high.
REQ-014 done  output  1  high when idle and ready for a command.
REQ-015 error  output  1  sticky flag: the last accepted command was rejected.

Function
REQ-016 States SHALL be IDLE, SETUP, WRITE and ERR.
REQ-017 In IDLE with enable=1 at a rising edge, the block SHALL latch mode, x_location, y_location, y_end and tile_value, and clear error.
- Next state is ERR if the command is invalid (REQ-018), otherwise SETUP.
REQ-018 A command is invalid when x_location >= TILEMAP_LENGTH, or when mode=1 and y_end < y_location.
REQ-019 SETUP SHALL last exactly one cycle, with wren=0; it registers address = x + y_location*TILEMAP_LENGTH.
REQ-020 WRITE SHALL assert memory_wren=1, drive the current address, and drive memory_data = latched tile_value.
REQ-021 In WRITE, if mode=0 or current row = y_end, the next state SHALL be IDLE; otherwise row increments, address increments by TILEMAP_LENGTH, and the block stays in WRITE.
REQ-022 Per-row address update SHALL be an add of TILEMAP_LENGTH, not a multiply.
- All address arithmetic is 15-bit unsigned; the maximum legal address is 31999, so no wrap is possible.
REQ-023 Latency for a single write: done low 2 cycles, wren high exactly 1 cycle.
- Column fill of n = y_end - y_location + 1 rows: done low n+1 cycles, wren high n consecutive cycles.
REQ-024 ERR SHALL last one cycle with wren=0 and done=0, then go to IDLE with error=1.
- error holds until the next accepted enable.
REQ-025 Fill with y_end = y_location SHALL write exactly one tile.
- A fill with y_location=0, y_end=15 writes all 16 rows.
REQ-026 enable SHALL be ignored outside IDLE; input changes after the accept edge have no effect.
REQ-027 When wren=0, memory_address and memory_data SHALL be driven to 0.
REQ-028 done SHALL be 1 only in IDLE.
REQ-029 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 resetn=0 SHALL immediately force state IDLE, memory_wren=0, memory_address=0, memory_data=0, error=0 and done=1.
REQ-031 Reset mid-fill SHALL abort the command.
- Tiles already written are not restored.
- No further writes occur until a new enable after reset release.

Structure
REQ-032 Package tilemap_pkg SHALL hold the shared definitions:
- TILEMAP_LENGTH and TILEMAP_ROWS;
- address width (15) and tile width (4);
- EMPTY_TILE = 0;
- the writer state encoding.
REQ-033 One sub-module, tilemap_address, SHALL be combinational and compute x + y*TILEMAP_LENGTH.
- It is used for the SETUP address.
- It is shareable with the background collision detector.

Verification
REQ-034 Single write, x=5, y=3, tile=7: one wren cycle with address 6005 and data 7; done low 2 cycles; error=0.
REQ-035 Fill, x=10, rows 2..5, tile=1: wren high 4 consecutive cycles with addresses 4010, 6010, 8010, 10010; done low 5 cycles.
REQ-036 Boundaries:
- single write at x=1999, y=15 -> address 31999;
- fill at x=0, rows 0..15 -> 16 writes, with addresses 0 through 30000 in steps of 2000.
REQ-037 Invalid commands:
- x=2000 -> no wren, error=1 two cycles after enable;
- fill with y_location=6, y_end=4 -> same response;
- a following valid command clears error at its accept edge.
REQ-038 Busy and reset:
- enable pulsed during a fill -> ignored;
- resetn low during the 2nd write of a 4-row fill -> wren=0 at once, done=1, no further writes after release.
